// File: rtl/wb_branch_resolve_if.sv
// Writeback/branch bundle from the ex4 stage into the resolve stage.
// This interface also carries the regfile, status and fetch-redirect results back.
interface wb_branch_resolve_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RAW = 5,
    parameter int unsigned CCW = 4,
    parameter int unsigned IAW = 10
);
    localparam int unsigned PW = 48;

    logic [RAW-1:0] addr_rd_i;
    logic           regfile_we_w_i;
    logic           regfile_we_uhw_i;
    logic           branchen_i;
    logic [CCW-1:0] condcode_i;
    logic [IAW-1:0] branchtrgt_i;
    logic           sr_we_i;
    logic [PW-1:0]  p_i;

    logic [RAW-1:0] rf_addr_o;
    logic [DW-1:0]  rf_data_o;
    logic           rf_we_hi_o;
    logic           rf_we_lo_o;
    logic [3:0]     sr_o;
    logic           pc_load_o;
    logic [IAW-1:0] pc_target_o;
    logic           flush_o;

    modport master (
        output addr_rd_i, regfile_we_w_i, regfile_we_uhw_i, branchen_i,
               condcode_i, branchtrgt_i, sr_we_i, p_i,
        input  rf_addr_o, rf_data_o, rf_we_hi_o, rf_we_lo_o, sr_o,
               pc_load_o, pc_target_o, flush_o
    );

    modport slave (
        input  addr_rd_i, regfile_we_w_i, regfile_we_uhw_i, branchen_i,
               condcode_i, branchtrgt_i, sr_we_i, p_i,
        output rf_addr_o, rf_data_o, rf_we_hi_o, rf_we_lo_o, sr_o,
               pc_load_o, pc_target_o, flush_o
    );
endinterface

// File: rtl/wb_branch_resolve.sv
// Writeback register stage with NZCV status register, branch resolution and
// a fixed-length wrong-path squash after each taken branch.
module wb_branch_resolve #(
    parameter int unsigned DW           = 32,
    parameter int unsigned RAW          = 5,
    parameter int unsigned CCW          = 4,
    parameter int unsigned IAW          = 10,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    wb_branch_resolve_if.slave  bus
);
    localparam int unsigned HW   = DW / 2;
    localparam int unsigned PW   = 48;
    localparam int unsigned CNTW = 4;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;

    logic       flag_n_c, flag_z_c, flag_c_c, flag_v_c;
    logic       old_lt_c;
    logic       cond_c;
    logic       valid_c;
    logic       taken_c;
    logic       unused_p_c;

    // Flags for this sample; the condition is judged on the SR as it stands now.
    always_comb begin
        flag_n_c = bus.p_i[DW-1];
        flag_z_c = (bus.p_i[DW-1:0] == '0);
        flag_c_c = bus.p_i[DW];
        flag_v_c = bus.p_i[DW] ^ bus.p_i[DW-1];
        old_lt_c = bus.sr_o[3] ^ bus.sr_o[0];
        cond_c   = 1'b0;
        case (bus.condcode_i)
            CCW'(0): cond_c = 1'b1;
            CCW'(1): cond_c = bus.sr_o[2];
            CCW'(2): cond_c = !bus.sr_o[2];
            CCW'(3): cond_c = old_lt_c;
            CCW'(4): cond_c = !old_lt_c;
            CCW'(5): cond_c = !bus.sr_o[2] && !old_lt_c;
            CCW'(6): cond_c = bus.sr_o[2] || old_lt_c;
            CCW'(7): cond_c = bus.sr_o[1];
            CCW'(8): cond_c = !bus.sr_o[1];
            default: cond_c = 1'b0;
        endcase
        valid_c = (state == IDLE);
        taken_c = valid_c && bus.branchen_i && cond_c;
    end

    assign unused_p_c = &{1'b0, bus.p_i[PW-1:DW+1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.rf_addr_o   <= '0;
            bus.rf_data_o   <= '0;
            bus.rf_we_hi_o  <= 1'b0;
            bus.rf_we_lo_o  <= 1'b0;
            bus.sr_o        <= '0;
            bus.pc_load_o   <= 1'b0;
            bus.pc_target_o <= '0;
            bus.flush_o     <= 1'b0;
        end else begin
            bus.rf_we_hi_o <= 1'b0;
            bus.rf_we_lo_o <= 1'b0;
            bus.pc_load_o  <= 1'b0;
            if (valid_c) begin
                if (bus.regfile_we_w_i) begin
                    bus.rf_addr_o  <= bus.addr_rd_i;
                    bus.rf_data_o  <= bus.p_i[DW-1:0];
                    bus.rf_we_hi_o <= 1'b1;
                    bus.rf_we_lo_o <= 1'b1;
                end else if (bus.regfile_we_uhw_i) begin
                    bus.rf_addr_o  <= bus.addr_rd_i;
                    bus.rf_data_o  <= {bus.p_i[HW-1:0], bus.p_i[HW-1:0]};
                    bus.rf_we_hi_o <= 1'b1;
                end
                if (bus.sr_we_i) begin
                    bus.sr_o <= {flag_n_c, flag_z_c, flag_c_c, flag_v_c};
                end
                if (taken_c) begin
                    bus.pc_load_o   <= 1'b1;
                    bus.pc_target_o <= bus.branchtrgt_i;
                    state           <= FLUSH;
                    cnt             <= CNTW'(FLUSH_CYCLES);
                    bus.flush_o     <= 1'b1;
                end
            end else begin
                // Squash this sample; the last one leaves the shadow.
                cnt <= cnt - CNTW'(1);
                if (cnt == CNTW'(1)) begin
                    state       <= IDLE;
                    bus.flush_o <= 1'b0;
                end
            end
        end
    end
endmodule
